keypad_entry_ctrl: RTL and testbench

Sequencing controller for the 10-line decimal keypad. It debounces the raw one-hot key lines, encodes each accepted key to BCD, and assembles up to DIGITS keystrokes into a packed multi-digit BCD number. The number is handed downstream over a valid/ready handshake. The block sits between the keypad pins and any consumer of entered numbers (display, comparator, arithmetic unit).

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_entry_ctrl_if.sv | 32 +++
 rtl/key_debounce.sv | 99 +++++++++
 rtl/keypad_entry_ctrl.sv | 119 +++++++++++
 tb/tb_keypad_entry_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    localparam logic [3:0] NO_KEY = 4'b1111;

    // Index of the set bit; NO_KEY when nothing is set.
    function automatic logic [3:0] onehot10_to_bcd(input logic [9:0] k);
        logic [3:0] r;
        r = NO_KEY;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic logic is_onehot10(input logic [9:0] k);
        return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: raw keys and control pulses in, accepted digits and number handshake out.
// Latency: n/a (wiring only).
// Backpressure: num_valid/num_ready handshake on the assembled number.
interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    localparam int NW = $clog2(DIGITS + 1);

    logic [9:0]          keys;
    logic                clr;
    logic                enter;
    logic                key_valid;
    logic [3:0]          key_bcd;
    logic [4*DIGITS-1:0] value;
    logic [NW-1:0]       ndigits;
    logic                num_valid;
    logic                num_ready;
    logic                err;

    // master: keypad pins plus downstream consumer
    modport master (
        output keys, clr, enter, num_ready,
        input  key_valid, key_bcd, value, ndigits, num_valid, err
    );

    // slave: the entry controller
    modport slave (
        input  keys, clr, enter, num_ready,
        output key_valid, key_bcd, value, ndigits, num_valid, err
    );

endinterface

// File: rtl/key_debounce.sv
// Debounces a 10-line key pattern: strobes once per stable press, then waits for a stable release.
// Latency: press strobe on the DEBOUNCE_CYCLES-th consecutive identical nonzero sample (combinational strobe).
// Backpressure: none; a key held through reset is locked out until released and debounced.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keys,
    output logic       press,
    output logic [9:0] pattern
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    kp_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [9:0]  pat_q, pat_d;
    logic        lock_q, lock_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pat_q   <= '0;
            lock_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pat_q   <= pat_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pat_d   = pat_q;
        lock_d  = lock_q;
        press   = 1'b0;
        case (state_q)
            IDLE: begin
                lock_d = 1'b0;
                if (keys != 10'd0) begin
                    // A key still down after reset is treated as already accepted.
                    if (lock_q) begin
                        state_d = HELD;
                    end else begin
                        pat_d   = keys;
                        count_d = CW'(1);
                        state_d = PRESS_DB;
                    end
                end
            end
            PRESS_DB: begin
                if (keys == pat_q) begin
                    if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        press   = 1'b1;
                        count_d = '0;
                        state_d = HELD;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (keys == 10'd0) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    pat_d   = keys;
                    count_d = CW'(1);
                end
            end
            HELD: begin
                if (keys == 10'd0) begin
                    count_d = CW'(1);
                    state_d = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (keys != 10'd0) begin
                    count_d = '0;
                    state_d = HELD;
                end else if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign pattern = pat_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced keys -> BCD digits -> packed multi-digit number; KEYPAD_SYNC_EN adds 2-flop input synchronizers.
// Latency: key_valid DEBOUNCE_CYCLES after keys settle, value one cycle later; enter -> num_valid in 1 cycle (+2 with sync).
// Backpressure: num_valid holds value frozen until num_ready; keys accepted meanwhile are reported but not appended.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    keypad_entry_ctrl_if.slave  kp
);
    localparam int NW = $clog2(DIGITS + 1);
    localparam int VW = 4 * DIGITS;

    logic [9:0] keys_s;
    logic       clr_s;
    logic       enter_s;

`ifdef KEYPAD_SYNC_EN
    logic [11:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {kp.enter, kp.clr, kp.keys};
            sync2_q <= sync1_q;
        end
    end

    assign keys_s  = sync2_q[9:0];
    assign clr_s   = sync2_q[10];
    assign enter_s = sync2_q[11];
`else
    assign keys_s  = kp.keys;
    assign clr_s   = kp.clr;
    assign enter_s = kp.enter;
`endif

    logic       db_press;
    logic [9:0] db_pat;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys_s),
        .press   (db_press),
        .pattern (db_pat)
    );

    logic          key_valid_q;
    logic [3:0]    key_bcd_q;
    logic [VW-1:0] value_q;
    logic [NW-1:0] ndigits_q;
    logic          num_valid_q;
    logic          err_q;

    logic          single;
    logic          room;
    logic          append;
    logic          overflow;
    logic [VW-1:0] value_app;

    assign single    = is_onehot10(db_pat);
    assign room      = (ndigits_q < NW'(DIGITS));
    // Appends act on the registered accept, one edge after key_valid rises.
    assign append    = key_valid_q && !num_valid_q && room;
    assign overflow  = key_valid_q && !num_valid_q && !room;
    assign value_app = (value_q << 4) | VW'(key_bcd_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_bcd_q   <= NO_KEY;
            value_q     <= '0;
            ndigits_q   <= '0;
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            key_valid_q <= db_press && single;
            err_q       <= (db_press && !single) || overflow;
            if (db_press && single) begin
                key_bcd_q <= onehot10_to_bcd(db_pat);
            end

            if (num_valid_q) begin
                if (kp.num_ready) begin
                    num_valid_q <= 1'b0;
                    value_q     <= '0;
                    ndigits_q   <= '0;
                end
            end else if (clr_s) begin
                value_q   <= '0;
                ndigits_q <= '0;
            end else begin
                if (append) begin
                    value_q   <= value_app;
                    ndigits_q <= ndigits_q + NW'(1);
                end
                if (enter_s && (append || (ndigits_q != '0))) begin
                    num_valid_q <= 1'b1;
                end
            end
        end
    end

    assign kp.key_valid = key_valid_q;
    assign kp.key_bcd   = key_bcd_q;
    assign kp.value     = value_q;
    assign kp.ndigits   = ndigits_q;
    assign kp.num_valid = num_valid_q;
    assign kp.err       = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with a queue of expected key_valid/err pulses.
// Latency: n/a. Backpressure: exercised through num_ready.
module tb_keypad_entry_ctrl;
    localparam int DIGITS = 4;
    localparam int DC     = 4;

    typedef struct packed {
        logic       kv;
        logic       er;
        logic [3:0] bcd;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    keypad_entry_ctrl_if #(.DIGITS(DIGITS)) kp ();

    keypad_entry_ctrl #(
        .DIGITS          (DIGITS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic kv, input logic er, input logic [3:0] bcd);
        ev_t e;
        e.kv  = kv;
        e.er  = er;
        e.bcd = bcd;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [9:0] k, input int hold);
        kp.keys = k;
        tick(hold);
        kp.keys = 10'd0;
        tick(DC + 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_valid"}, 32'(kp.key_valid), 32'd0);
        chk({tag, "_key_bcd"},   32'(kp.key_bcd),   32'hF);
        chk({tag, "_value"},     32'(kp.value),     32'd0);
        chk({tag, "_ndigits"},   32'(kp.ndigits),   32'd0);
        chk({tag, "_num_valid"}, 32'(kp.num_valid), 32'd0);
        chk({tag, "_err"},       32'(kp.err),       32'd0);
    endtask

    // Every key_valid/err pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (kp.key_valid || kp.err)) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: observed kv=%0b err=%0b bcd=%0h expected no pulse",
                       kp.key_valid, kp.err, kp.key_bcd);
            end
            if (exp_q.size() > 0) begin
                ev_t e;
                ev_t o;
                e = exp_q.pop_front();
                o.kv  = kp.key_valid;
                o.er  = kp.err;
                o.bcd = kp.key_bcd;
                checks++;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL pulse: observed kv=%0b err=%0b bcd=%0h expected kv=%0b err=%0b bcd=%0h",
                           o.kv, o.er, o.bcd, e.kv, e.er, e.bcd);
                end
            end
        end
    end

    initial begin
        logic [9:0] k;
        kp.keys      = 10'd0;
        kp.clr       = 1'b0;
        kp.enter     = 1'b0;
        kp.num_ready = 1'b0;

        rst = 1'b1;
        tick(2);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(2);

        // Single key 3, held exactly DC cycles.
        push(1'b1, 1'b0, 4'd3);
        press(10'h008, DC);
        chk("k3_value",   32'(kp.value),   32'h0003);
        chk("k3_ndigits", 32'(kp.ndigits), 32'd1);

        // One cycle short of the debounce window: no accept.
        press(10'h040, DC - 1);
        chk("short_value", 32'(kp.value), 32'h0003);

        kp.clr = 1'b1; tick(1); kp.clr = 1'b0;
        chk("clr_value",   32'(kp.value),   32'h0);
        chk("clr_ndigits", 32'(kp.ndigits), 32'd0);

        // Fill to DIGITS, fifth digit overflows.
        for (int d = 1; d <= 5; d++) begin
            k = 10'(1) << d;
            push(1'b1, 1'b0, 4'(d));
            if (d == 5) push(1'b0, 1'b1, 4'd5);
            press(k, DC);
        end
        chk("full_value",   32'(kp.value),   32'h1234);
        chk("full_ndigits", 32'(kp.ndigits), 32'd4);

        kp.clr = 1'b1; tick(1); kp.clr = 1'b0;

        // Bouncing line, then stable.
        for (int i = 0; i < 10; i++) begin
            kp.keys = (i % 2 == 0) ? 10'h020 : 10'h000;
            tick(1);
        end
        push(1'b1, 1'b0, 4'd5);
        press(10'h020, DC);
        chk("bounce_value", 32'(kp.value),   32'h0005);
        chk("bounce_bcd",   32'(kp.key_bcd), 32'd5);

        kp.clr = 1'b1; tick(1); kp.clr = 1'b0;

        // Two keys at once.
        push(1'b0, 1'b1, 4'd5);
        press(10'h003, DC);
        chk("multi_value",   32'(kp.value),   32'h0);
        chk("multi_ndigits", 32'(kp.ndigits), 32'd0);

        // 7, 9, enter, held off by the consumer.
        push(1'b1, 1'b0, 4'd7);
        press(10'h080, DC);
        push(1'b1, 1'b0, 4'd9);
        press(10'h200, DC);
        kp.enter = 1'b1; tick(1); kp.enter = 1'b0;
        chk("enter_num_valid", 32'(kp.num_valid), 32'd1);
        tick(5);
        chk("wait_num_valid", 32'(kp.num_valid), 32'd1);
        chk("wait_value",     32'(kp.value),     32'h0079);
        push(1'b1, 1'b0, 4'd2);
        press(10'h004, DC);
        kp.clr = 1'b1; tick(1); kp.clr = 1'b0;
        chk("frozen_value",   32'(kp.value),     32'h0079);
        chk("frozen_ndigits", 32'(kp.ndigits),   32'd2);
        chk("frozen_valid",   32'(kp.num_valid), 32'd1);
        kp.num_ready = 1'b1; tick(1); kp.num_ready = 1'b0;
        chk("hs_num_valid", 32'(kp.num_valid), 32'd0);
        chk("hs_value",     32'(kp.value),     32'h0);
        chk("hs_ndigits",   32'(kp.ndigits),   32'd0);

        // enter with nothing entered.
        kp.enter = 1'b1; tick(1); kp.enter = 1'b0;
        chk("empty_enter", 32'(kp.num_valid), 32'd0);

        // clr on the same cycle as a digit accept.
        push(1'b1, 1'b0, 4'd6);
        press(10'h040, DC);
        chk("pre_clr_value", 32'(kp.value), 32'h0006);
        push(1'b1, 1'b0, 4'd8);
        kp.keys = 10'h100;
        tick(DC);
        kp.keys = 10'd0;
        kp.clr  = 1'b1; tick(1); kp.clr = 1'b0;
        chk("clr_wins_value",   32'(kp.value),   32'h0);
        chk("clr_wins_ndigits", 32'(kp.ndigits), 32'd0);
        tick(DC + 2);

        // enter on the same cycle as the first digit accept.
        push(1'b1, 1'b0, 4'd4);
        kp.keys = 10'h010;
        tick(DC);
        kp.keys  = 10'd0;
        kp.enter = 1'b1; tick(1); kp.enter = 1'b0;
        chk("enter_same_valid", 32'(kp.num_valid), 32'd1);
        chk("enter_same_value", 32'(kp.value),     32'h0004);
        kp.num_ready = 1'b1; tick(1); kp.num_ready = 1'b0;
        chk("enter_same_hs", 32'(kp.num_valid), 32'd0);
        tick(DC + 2);

        // Reset in the middle of a press, key kept down through reset.
        push(1'b1, 1'b0, 4'd9);
        press(10'h200, DC);
        kp.keys = 10'h002;
        tick(2);
        rst = 1'b1; tick(1);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        tick(2 * DC + 2);
        chk("held_through_rst_bcd",     32'(kp.key_bcd), 32'hF);
        chk("held_through_rst_ndigits", 32'(kp.ndigits), 32'd0);
        kp.keys = 10'd0;
        tick(DC + 2);
        push(1'b1, 1'b0, 4'd1);
        press(10'h002, DC);
        chk("after_rst_value", 32'(kp.value), 32'h0001);

        tick(4);
        chk("pending_events", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
